// File: rtl/seq_multiplier_32bit.sv
// Iterative 32x32->64 shift-add multiplier (MULT/MULTU) driving an external 32-bit adder.
// Optional MULT_ZERO_BYPASS_EN: zero operands finish at the accept edge without iterating.
module seq_multiplier_32bit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;
  logic             neg;
  logic             accept;
  logic             bypass;
  logic             last_step;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign last_step = (count == CW'(ITERS - 1));
  assign abs_a     = (sgn && op_a[WIDTH-1]) ? ('0 - op_a) : op_a;
  assign abs_b     = (sgn && op_b[WIDTH-1]) ? ('0 - op_b) : op_b;

`ifdef MULT_ZERO_BYPASS_EN
  assign bypass = (op_a == '0) || (op_b == '0);
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    add_a      = '0;
    add_b      = '0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = bypass ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy  = 1'b1;
        add_a = hi;
        add_b = lo[0] ? mcand : '0;
        if (last_step) state_next = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (accept) state_next = bypass ? S_DONE : S_CALC;
        else        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      neg   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            mcand <= abs_a;
            hi    <= '0;
            lo    <= bypass ? '0 : abs_b;
            neg   <= sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            count <= '0;
          end
        end
        S_CALC: begin
          // Right shift of the 65-bit {cout, sum, lo}: the multiplier bits drain out of lo
          // as product bits shift in.
          {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
          count    <= count + CW'(1);
        end
        S_FIX: begin
          if (neg) {hi, lo} <= '0 - {hi, lo};
        end
        default: ;
      endcase
    end
  end

endmodule
